// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// FSM state encodings and the reset PC value.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int RESET_PC    = 0;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE    = 2'd0;
  localparam fetch_state_t ST_WAIT    = 2'd1;
  localparam fetch_state_t ST_DISCARD = 2'd2;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {address, instruction} pairs.
// Pushed entries appear at the head one cycle later; clear beats push and pop.
module fetch_queue #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head reads as zero while empty so stale entries never leak out.
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; validity lives entirely in the pointers/count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC register load, fetches over a
// req/ack memory port and queues instructions for the decoder.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               pc_hold,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_addr
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t             state;
  logic [CNT_W-1:0]         q_count;
  logic                     q_empty;
  logic                     issue;
  logic                     push;
  logic                     ack_in_wait;
  logic [ADDR_W+INSTR_W-1:0] q_head;

  assign ack_in_wait = (state == ST_WAIT) && imem_ack;
  assign issue       = (state == ST_IDLE) && !flush && (q_count < CNT_W'(DEPTH));
  assign push        = ack_in_wait && !flush;

  assign pc_hold = !(reset || flush || ack_in_wait);

  // NOTE: every path assigns pc_next, so this stays combinational with no latch.
  always_comb begin
    if (reset)      pc_next = ADDR_W'(RESET_PC);
    else if (flush) pc_next = flush_target;
    else            pc_next = pc_addr + ADDR_W'(1);
  end

  // The memory port cannot abort, so a flushed in-flight read is drained in DISCARD.
  // NOTE: state registers use non-blocking assignments so all updates land together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            imem_req  <= 1'b1;
            imem_addr <= pc_addr;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= ST_IDLE;
          end else if (flush) begin
            state <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  fetch_queue #(
    .WIDTH (ADDR_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({imem_addr, imem_rdata}),
    .pop       (instr_valid && instr_ready),
    .clear     (flush),
    .head_data (q_head),
    .count     (q_count),
    .empty     (q_empty)
  );

  assign instr_valid = !q_empty;
  assign instr_addr  = q_head[ADDR_W+INSTR_W-1:INSTR_W];
  assign instr_data  = q_head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC register and memory models around the
// DUT, with a scoreboard of expected {addr, word} pairs checked at the decoder.
module tb_fetch_unit;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic [ADDR_W-1:0]  pc_addr;
  logic [ADDR_W-1:0]  pc_next;
  logic               pc_hold;
  logic               flush;
  logic [ADDR_W-1:0]  flush_target;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_addr;

  logic [ADDR_W-1:0]  pc;

  always #5 clock = ~clock;

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pc_addr      (pc_addr),
    .pc_next      (pc_next),
    .pc_hold      (pc_hold),
    .flush        (flush),
    .flush_target (flush_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_data   (instr_data),
    .instr_addr   (instr_addr)
  );

  function automatic logic [INSTR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  // PC register
  always_ff @(posedge clock) begin
    if (!pc_hold) pc <= pc_next;
  end
  assign pc_addr = pc;

  // Instruction memory: acks one cycle after it sees a request.
  always_ff @(posedge clock) begin
    if (reset) begin
      imem_ack   <= 1'b0;
      imem_rdata <= '0;
    end else begin
      imem_ack   <= imem_req && !imem_ack;
      imem_rdata <= word_of(imem_addr);
    end
  end

  // Decoder ready: fixed level or random.
  bit rand_ready;
  bit ready_fixed;
  always @(posedge clock) begin
    #1;
    instr_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_popped = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] data;
  } entry_t;

  entry_t            sb[$];
  logic [ADDR_W-1:0] exp_addr;
  bit                req_seen;
  bit                killed;

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clock) begin
    entry_t e;
    if (reset) begin
      sb.delete();
      exp_addr = '0;
      req_seen = 1'b0;
      killed   = 1'b0;
    end else begin
      check("instr_valid", 32'(instr_valid), 32'(sb.size() != 0));
      if (imem_req && !req_seen) begin
        check("req_addr", 32'(imem_addr), 32'(exp_addr));
        req_seen = 1'b1;
      end
      if (instr_valid && instr_ready && !flush && sb.size() != 0) begin
        e = sb.pop_front();
        check("instr_addr", 32'(instr_addr), 32'(e.addr));
        check("instr_data", 32'(instr_data), 32'(e.data));
        n_popped++;
      end
      if (flush) begin
        if (imem_req && !imem_ack) begin
          killed = 1'b1;
        end else begin
          req_seen = 1'b0;
          killed   = 1'b0;
        end
        sb.delete();
        exp_addr = flush_target;
      end else if (imem_ack) begin
        if (!killed) begin
          check("pc_hold_ack", 32'(pc_hold), 32'(0));
          check("pc_next_ack", 32'(pc_next), 32'(ADDR_W'(exp_addr + 8'd1)));
          sb.push_back('{exp_addr, word_of(exp_addr)});
          exp_addr = exp_addr + 8'd1;
        end
        req_seen = 1'b0;
        killed   = 1'b0;
      end
    end
  end

  function automatic bit cond_met(input int kind, input logic [ADDR_W-1:0] a);
    case (kind)
      0:       return imem_req && imem_addr == a && !imem_ack;
      1:       return imem_req && imem_addr == a && imem_ack;
      2:       return imem_ack && imem_addr == a && !flush;
      3:       return imem_req && !imem_ack;
      default: return imem_req && imem_addr != a;
    endcase
  endfunction

  // Tasks below start and end at posedge+1.
  task automatic wait_for(input int kind, input logic [ADDR_W-1:0] a, input int budget,
                          output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cond_met(kind, a)) begin
        found = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    bit found;
    reset        = 1'b1;
    flush        = 1'b0;
    flush_target = '0;
    rand_ready   = 1'b0;
    ready_fixed  = 1'b1;
    instr_ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_pc_hold", 32'(pc_hold), 32'(0));
    check("rst_pc_next", 32'(pc_next), 32'(0));
    check("rst_pc", 32'(pc), 32'(0));
    check("rst_imem_req", 32'(imem_req), 32'(0));
    check("rst_imem_addr", 32'(imem_addr), 32'(0));
    check("rst_instr_valid", 32'(instr_valid), 32'(0));
    check("rst_instr_data", 32'(instr_data), 32'(0));
    check("rst_instr_addr", 32'(instr_addr), 32'(0));
    reset = 1'b0;

    // Sequential fetch, decoder always ready
    run(20);
    check("seq_progress", 32'(n_popped >= 3), 32'(1));

    // Decoder stalled: queue fills, then fetching stops with PC held
    ready_fixed = 1'b0;
    do_reset();
    run(20);
    check("full_imem_req", 32'(imem_req), 32'(0));
    check("full_pc_hold", 32'(pc_hold), 32'(1));
    check("full_instr_valid", 32'(instr_valid), 32'(1));
    check("full_pc", 32'(pc), 32'(8'h02));
    ready_fixed = 1'b1;
    wait_for(3, 8'h00, 12, found);
    check("resume_found", 32'(found), 32'(1));
    check("resume_addr", 32'(imem_addr), 32'(8'h02));
    run(10);

    // Wrap from 0xFF to 0x00
    rand_ready   = 1'b1;
    flush        = 1'b1;
    flush_target = 8'hFE;
    run(1);
    flush = 1'b0;
    wait_for(2, 8'hFF, 60, found);
    check("wrap_found", 32'(found), 32'(1));
    check("wrap_pc_next", 32'(pc_next), 32'(8'h00));
    check("wrap_pc_hold", 32'(pc_hold), 32'(0));
    run(1);
    check("wrap_pc", 32'(pc), 32'(8'h00));
    run(12);

    // Flush during WAIT at 0x05 -> DISCARD, redirect to 0x40
    do_reset();
    wait_for(0, 8'h05, 120, found);
    check("fw_found", 32'(found), 32'(1));
    flush        = 1'b1;
    flush_target = 8'h40;
    #1;
    check("fw_pc_hold", 32'(pc_hold), 32'(0));
    check("fw_pc_next", 32'(pc_next), 32'(8'h40));
    @(posedge clock);
    #1;
    flush = 1'b0;
    check("fw_instr_valid", 32'(instr_valid), 32'(0));
    check("fw_pc", 32'(pc), 32'(8'h40));
    check("fw_discard_req", 32'(imem_req), 32'(1));
    check("fw_discard_addr", 32'(imem_addr), 32'(8'h05));
    wait_for(4, 8'h05, 12, found);
    check("fw_next_found", 32'(found), 32'(1));
    check("fw_next_addr", 32'(imem_addr), 32'(8'h40));
    run(12);

    // Flush coincident with ack at 0x07 -> word dropped, redirect to 0x10
    do_reset();
    wait_for(1, 8'h07, 150, found);
    check("fa_found", 32'(found), 32'(1));
    flush        = 1'b1;
    flush_target = 8'h10;
    #1;
    check("fa_pc_next", 32'(pc_next), 32'(8'h10));
    @(posedge clock);
    #1;
    flush = 1'b0;
    check("fa_instr_valid", 32'(instr_valid), 32'(0));
    check("fa_imem_req", 32'(imem_req), 32'(0));
    check("fa_pc", 32'(pc), 32'(8'h10));
    wait_for(3, 8'h00, 12, found);
    check("fa_next_found", 32'(found), 32'(1));
    check("fa_next_addr", 32'(imem_addr), 32'(8'h10));
    run(12);

    // Reset asserted while a request is outstanding
    wait_for(3, 8'h00, 20, found);
    check("rw_found", 32'(found), 32'(1));
    reset = 1'b1;
    #1;
    check("rw_pc_hold", 32'(pc_hold), 32'(0));
    check("rw_pc_next", 32'(pc_next), 32'(0));
    @(posedge clock);
    #1;
    check("rw_imem_req", 32'(imem_req), 32'(0));
    check("rw_instr_valid", 32'(instr_valid), 32'(0));
    check("rw_pc", 32'(pc), 32'(0));
    reset = 1'b0;
    run(16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage wrapped around the program-counter register. Each cycle it decides whether the PC loads and with what value: sequential increment after every completed fetch, or a redirect target on flush. It fetches the instruction at the current PC address from instruction memory over a req/ack handshake. It buffers fetched instructions in a small queue and delivers them to the decoder over a valid/ready interface.

## Interface
- ADDR_W, 8, instruction address width; matches PC width
- INSTR_W, 16, instruction word width
- DEPTH, 2, instruction queue entries; power of two, ≥2

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- pc_addr  in  ADDR_W  current PC value (PC register output)
- pc_next  out  ADDR_W  value the PC loads (PC register data input)
- pc_hold  out  1  PC load control: 0 = PC loads pc_next (or clears on reset) at next edge, 1 = PC holds
- flush  in  1  redirect request from execute (branch/jump taken)
- flush_target  in  ADDR_W  redirect address, valid with flush
- imem_req  out  1  read request, registered
- imem_addr  out  ADDR_W  read address, registered
- imem_ack  in  1  read data valid, one-cycle pulse
- imem_rdata  in  INSTR_W  read data, valid with imem_ack
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decoder accepts head
- instr_data  out  INSTR_W  queue head instruction
- instr_addr  out  ADDR_W  address of queue head instruction

## Operation
- States: IDLE, WAIT, DISCARD.
- IDLE: if queue count < DEPTH and not flush → imem_req=1, imem_addr=pc_addr, go WAIT. Otherwise stay IDLE with imem_req=0.
- WAIT: imem_req and imem_addr held stable until imem_ack.
  - On ack: push {imem_addr, imem_rdata}, deassert req, go IDLE.
  - PC advances at the same edge: pc_next=pc_addr+1, modulo 2^ADDR_W (0xFF→0x00).
- DISCARD: req/addr held stable until ack; ack data dropped; go IDLE. The memory protocol has no abort.
- pc_hold is combinational: 0 when reset, flush, or (WAIT and imem_ack); else 1.
- pc_next mux priority: reset → 0; flush → flush_target; otherwise pc_addr+1.
- Flush, any state:
  - queue emptied at that edge; a same-cycle pop is ignored.
  - PC loads flush_target.
  - IDLE → IDLE. WAIT without ack → DISCARD. WAIT with ack → data dropped, IDLE.
- Flush in DISCARD: PC reloads the new target; stay DISCARD, or go IDLE if ack arrives the same cycle.
- Queue: FIFO, push and pop in the same cycle allowed when full or empty-with-push. Pop when instr_valid && instr_ready. No fall-through: a pushed entry becomes visible the next cycle.

## Timing
- Reset values: state IDLE, imem_req=0, imem_addr=0, queue empty, instr_valid=0, instr_data=0, instr_addr=0.
- During reset pc_hold=0 and pc_next=0, so the PC clears.
- Reset mid-transaction abandons the request. Instruction memory is reset by the same signal.
- Fetch latency: IDLE cycle, then ≥1 WAIT cycle. With a same-cycle ack, instr_valid rises 2 cycles after the IDLE issue cycle. Peak throughput is 1 instruction per 2 cycles.
- Queue full: no new request; PC held (pc_hold=1).
- Reset has priority over flush.

## Structure
- Shared package `fetch_pkg`: state enum (IDLE/WAIT/DISCARD), ADDR_W/INSTR_W defaults, reset PC constant 0.
- Sub-module `fetch_queue`: parameterised synchronous FIFO with width ADDR_W+INSTR_W, DEPTH entries, push/pop/clear, count, full/empty.
- FSM and PC mux live in the top module.

## Test plan
- Reset then pc_addr tracking, memory acks 1 cycle after req, decoder always ready:
  - during reset, pc_hold=0 and pc_next=0x00.
  - fetch addresses go 0x00, 0x01, 0x02.
  - instr_data matches memory words in order, instr_addr matches.
- Decoder ready=0 with DEPTH=2: two fetches complete, then imem_req stays 0 and pc_hold=1. Raise ready → fetching resumes at 0x02.
- Wrap: PC=0xFF, ack → pc_next=0x00, instr_addr=0xFF.
- Flush during WAIT (addr 0x05) with target 0x40:
  - queue empties and PC loads 0x40.
  - DISCARD until the 0x05 ack; that word never appears.
  - next request is to 0x40.
- Flush coincident with ack at 0x07 (target 0x10) → word dropped, queue empty, next request 0x10.
- Reset asserted in WAIT → next cycle imem_req=0, instr_valid=0, PC=0x00.
